// File: rtl/dlrom_wide.sv
// Download-loaded ROM: packs a byte-wide download stream into DW-bit words
// and serves a registered single-port read.
// Latency: read data one edge after AD; a committed pack reaches memory one
// edge after the commit.
// Backpressure: none. A byte in the window is accepted every cycle DLEN=1.
//
// Ports:
//   CL, RESET      clock and synchronous active-high reset
//   AD / DT        read word address and registered read data
//   DLAD/DLDT/DLEN download byte address, byte, qualifying strobe
//   DLFIN          end-of-download strobe (flush the pack, then raise LOADED)
//   CSUM           modulo-2^16 sum of accepted bytes
//   WCNT           committed-word count, saturating at 2**AW
//   LOADED         final flush has reached memory
module dlrom_wide #(
  parameter int          AW   = 14,
  parameter int          DW   = 16,
  parameter logic [19:0] BASE = 20'h00000
) (
  input  logic          CL,
  input  logic          RESET,
  input  logic [AW-1:0] AD,
  output logic [DW-1:0] DT,
  input  logic [19:0]   DLAD,
  input  logic [7:0]    DLDT,
  input  logic          DLEN,
  input  logic          DLFIN,
  output logic [15:0]   CSUM,
  output logic [AW:0]   WCNT,
  output logic          LOADED
);

  localparam int          L    = DW / 8;
  localparam int          LW   = (L > 1) ? $clog2(L) : 1;
  localparam logic [19:0] L20  = 20'(L);
  localparam logic [31:0] WIN  = 32'(L) << AW;
  localparam logic [AW:0] WMAX = {1'b1, {AW{1'b0}}};

  // FLUSH waits for the last commit to drain through the write stage.
  typedef enum logic [1:0] {S_IDLE, S_PEND, S_FLUSH, S_DONE} state_t;
  state_t state, state_n;

  logic [DW-1:0] mem [0:(2**AW)-1];

  logic [AW-1:0] pa, pa_n;
  logic [DW-1:0] pd, pd_n;
  logic [L-1:0]  pm, pm_n;

  logic          cm_vld;
  logic [AW-1:0] cm_addr;
  logic [DW-1:0] cm_data;
  logic [L-1:0]  cm_mask;

  logic [AW-1:0] ws_addr;
  logic [DW-1:0] ws_data;
  logic [L-1:0]  ws_en;

  logic [19:0]   ofs, word_full, lane_full;
  logic [AW-1:0] word;
  logic [LW-1:0] lane;
  logic [L-1:0]  lane_bit;
  logic          accept;
  logic          unused_bits;

  assign ofs       = DLAD - BASE;
  assign word_full = ofs / L20;
  assign lane_full = ofs % L20;
  assign word      = word_full[AW-1:0];
  assign lane      = lane_full[LW-1:0];
  assign lane_bit  = L'(1) << lane;
  // DLAD >= BASE guards the wrap of the 20-bit subtraction.
  assign accept    = DLEN && (DLAD >= BASE) && ({12'd0, ofs} < WIN);
  assign unused_bits = ^{word_full, lane_full};

  assign LOADED = (state == S_DONE);

  always_comb begin
    state_n = state;
    pa_n    = pa;
    pd_n    = pd;
    pm_n    = pm;
    cm_vld  = 1'b0;
    cm_addr = pa;
    cm_data = pd;
    cm_mask = pm;

    if (accept) begin
      // Byte for a different word: retire the old pack as-is (partial mask).
      if ((pm != '0) && (word != pa)) begin
        cm_vld = 1'b1;
        pm_n   = '0;
      end
      pa_n                 = word;
      pd_n[lane*8 +: 8]    = DLDT;
      pm_n                 = pm_n | lane_bit;
      // A full pack only arises from a merge, so it never collides with the
      // old-pack commit above.
      if (&pm_n) begin
        cm_vld  = 1'b1;
        cm_addr = pa_n;
        cm_data = pd_n;
        cm_mask = pm_n;
        pm_n    = '0;
      end
      state_n = (pm_n != '0) ? S_PEND : S_IDLE;
    end

    if (DLFIN) begin
      // If the commit slot is already taken this cycle, the new pack stays
      // pending and FLUSH retires it on the next cycle.
      if ((pm_n != '0) && !cm_vld) begin
        cm_vld  = 1'b1;
        cm_addr = pa_n;
        cm_data = pd_n;
        cm_mask = pm_n;
        pm_n    = '0;
      end
      if (cm_vld || (pm_n != '0) || (ws_en != '0)) state_n = S_FLUSH;
      else                                        state_n = S_DONE;
    end else if (!accept && (state == S_FLUSH)) begin
      if (pm != '0) begin
        cm_vld = 1'b1;
        pm_n   = '0;
      end else if (ws_en == '0) begin
        state_n = S_DONE;
      end
    end
  end

  always_ff @(posedge CL) begin
    if (RESET) begin
      state   <= S_IDLE;
      pa      <= '0;
      pd      <= '0;
      pm      <= '0;
      ws_en   <= '0;
      ws_addr <= '0;
      ws_data <= '0;
      CSUM    <= '0;
      WCNT    <= '0;
      DT      <= '0;
    end else begin
      state   <= state_n;
      pa      <= pa_n;
      pd      <= pd_n;
      pm      <= pm_n;
      ws_en   <= cm_vld ? cm_mask : '0;
      ws_addr <= cm_addr;
      ws_data <= cm_data;
      if (accept) CSUM <= CSUM + 16'(DLDT);
      if (cm_vld && (WCNT != WMAX)) WCNT <= WCNT + 1'b1;
      DT <= mem[AD];
    end
  end

  // Memory is never cleared; only enabled lanes are written.
  always_ff @(posedge CL) begin
    if (!RESET) begin
      for (int i = 0; i < L; i++) begin
        if (ws_en[i]) mem[ws_addr][i*8 +: 8] <= ws_data[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dlrom_wide.sv
// Bench for dlrom_wide with DW=16, AW=4, BASE=20'h40000.
// Download vectors come from a table with hand-computed CSUM/WCNT; reads go
// through an expected-value queue popped as DT is produced.
module tb_dlrom_wide;

  logic        CL;
  logic        RESET;
  logic [3:0]  AD;
  logic [15:0] DT;
  logic [19:0] DLAD;
  logic [7:0]  DLDT;
  logic        DLEN;
  logic        DLFIN;
  logic [15:0] CSUM;
  logic [4:0]  WCNT;
  logic        LOADED;

  dlrom_wide #(.AW(4), .DW(16), .BASE(20'h40000)) dut (
    .CL(CL), .RESET(RESET), .AD(AD), .DT(DT),
    .DLAD(DLAD), .DLDT(DLDT), .DLEN(DLEN), .DLFIN(DLFIN),
    .CSUM(CSUM), .WCNT(WCNT), .LOADED(LOADED)
  );

  initial CL = 1'b0;
  always #5 CL = ~CL;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [19:0] ad;
    logic [7:0]  dt;
    logic [15:0] csum;
    logic [4:0]  wcnt;
  } vec_t;

  typedef struct {
    logic [3:0]  ad;
    logic [15:0] exp;
    logic [15:0] mask;
  } rd_t;

  vec_t tbl[10];
  rd_t  rq[$];
  rd_t  sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CL);
    #1;
  endtask

  task automatic send(input logic [19:0] ad, input logic [7:0] dt, input logic fin);
    DLAD = ad; DLDT = dt; DLEN = 1'b1; DLFIN = fin;
    tick();
    DLEN = 1'b0; DLFIN = 1'b0;
  endtask

  task automatic fin_only();
    DLFIN = 1'b1;
    tick();
    DLFIN = 1'b0;
  endtask

  // One idle edge so the last commit lands, then one read per edge.
  task automatic run_reads();
    rd_t r, e;
    tick();
    while (rq.size() > 0) begin
      r  = rq.pop_front();
      AD = r.ad;
      sb.push_back(r);
      tick();
      e = sb.pop_front();
      check($sformatf("rd mem[%0d]", e.ad), {16'd0, DT & e.mask}, {16'd0, e.exp});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    tbl[0] = '{20'h40000, 8'h34, 16'h0034, 5'd0};
    tbl[1] = '{20'h40001, 8'h12, 16'h0046, 5'd1};
    tbl[2] = '{20'h40002, 8'hCD, 16'h0113, 5'd1};
    tbl[3] = '{20'h40003, 8'hAB, 16'h01BE, 5'd2};
    tbl[4] = '{20'h3FFFF, 8'h77, 16'h01BE, 5'd2};
    tbl[5] = '{20'h40020, 8'h88, 16'h01BE, 5'd2};
    tbl[6] = '{20'h40005, 8'hEF, 16'h02AD, 5'd2};
    tbl[7] = '{20'h40004, 8'h01, 16'h02AE, 5'd3};
    tbl[8] = '{20'h4001F, 8'h99, 16'h0347, 5'd3};
    tbl[9] = '{20'h4001E, 8'h66, 16'h03AD, 5'd4};

    RESET = 1'b1; AD = '0; DLAD = '0; DLDT = '0; DLEN = 1'b0; DLFIN = 1'b0;
    tick(); tick();
    RESET = 1'b0;
    check("reset DT", {16'd0, DT}, 32'h0);
    check("reset CSUM", {16'd0, CSUM}, 32'h0);
    check("reset WCNT", {27'd0, WCNT}, 32'h0);
    check("reset LOADED", {31'd0, LOADED}, 32'h0);

    // Table: in-window pairs, out-of-window bytes, reversed lane order, top word.
    for (int i = 0; i < 10; i++) begin
      send(tbl[i].ad, tbl[i].dt, 1'b0);
      check($sformatf("vec%0d CSUM", i), {16'd0, CSUM}, {16'd0, tbl[i].csum});
      check($sformatf("vec%0d WCNT", i), {27'd0, WCNT}, {27'd0, tbl[i].wcnt});
    end
    rq.push_back('{4'd0,  16'h1234, 16'hFFFF});
    rq.push_back('{4'd1,  16'hABCD, 16'hFFFF});
    rq.push_back('{4'd2,  16'hEF01, 16'hFFFF});
    rq.push_back('{4'd15, 16'h9966, 16'hFFFF});
    run_reads();

    // Read-before-write while word 0 is rewritten.
    AD = 4'd0;
    tick();
    send(20'h40000, 8'h78, 1'b0);
    send(20'h40001, 8'h56, 1'b0);
    check("rbw commit edge", {16'd0, DT}, 32'h1234);
    tick();
    check("rbw write edge", {16'd0, DT}, 32'h1234);
    tick();
    check("rbw after write", {16'd0, DT}, 32'h5678);
    check("rbw WCNT", {27'd0, WCNT}, 32'd5);
    check("rbw CSUM", {16'd0, CSUM}, 32'h047B);

    // Partial commit of the high lane, then a pending pack for word 2.
    send(20'h40003, 8'h5A, 1'b0);
    check("partial WCNT before", {27'd0, WCNT}, 32'd5);
    send(20'h40004, 8'h11, 1'b0);
    check("partial WCNT commit", {27'd0, WCNT}, 32'd6);
    send(20'h40005, 8'h22, 1'b0);
    check("pend word2 WCNT", {27'd0, WCNT}, 32'd7);
    check("pend word2 CSUM", {16'd0, CSUM}, 32'h0508);
    rq.push_back('{4'd1, 16'h5ACD, 16'hFFFF});
    rq.push_back('{4'd2, 16'h2211, 16'hFFFF});
    run_reads();

    // Byte coinciding with DLFIN: LOADED on the third edge.
    send(20'h40006, 8'h55, 1'b1);
    check("fin+byte LOADED e0", {31'd0, LOADED}, 32'd0);
    check("fin+byte WCNT", {27'd0, WCNT}, 32'd8);
    tick();
    check("fin+byte LOADED e1", {31'd0, LOADED}, 32'd0);
    tick();
    check("fin+byte LOADED e2", {31'd0, LOADED}, 32'd1);
    rq.push_back('{4'd3, 16'h0055, 16'h00FF});
    run_reads();
    check("loaded holds", {31'd0, LOADED}, 32'd1);

    // Reload after LOADED, then a flush of a lone pending lane.
    send(20'h40007, 8'h44, 1'b0);
    check("reload clears LOADED", {31'd0, LOADED}, 32'd0);
    fin_only();
    check("flush LOADED e0", {31'd0, LOADED}, 32'd0);
    check("flush WCNT", {27'd0, WCNT}, 32'd9);
    tick();
    check("flush LOADED e1", {31'd0, LOADED}, 32'd0);
    tick();
    check("flush LOADED e2", {31'd0, LOADED}, 32'd1);
    check("flush CSUM", {16'd0, CSUM}, 32'h05A1);
    rq.push_back('{4'd3, 16'h4455, 16'hFFFF});
    run_reads();

    // Reset with a lane pending and a completing byte in the same cycle.
    send(20'h40000, 8'h99, 1'b0);
    RESET = 1'b1; DLEN = 1'b1; DLAD = 20'h40001; DLDT = 8'h11;
    tick();
    RESET = 1'b0; DLEN = 1'b0;
    check("rst pend CSUM", {16'd0, CSUM}, 32'h0);
    check("rst pend WCNT", {27'd0, WCNT}, 32'h0);
    check("rst pend LOADED", {31'd0, LOADED}, 32'h0);
    check("rst pend DT", {16'd0, DT}, 32'h0);
    rq.push_back('{4'd0, 16'h5678, 16'hFFFF});
    run_reads();

    // DLFIN with nothing pending sets LOADED on the next edge.
    fin_only();
    check("idle fin LOADED", {31'd0, LOADED}, 32'd1);

    // WCNT saturation at 2**AW.
    for (int i = 0; i < 18; i++) begin
      send(20'h40000 + 20'(2 * (i % 16)), 8'(i), 1'b0);
      send(20'h40001 + 20'(2 * (i % 16)), 8'(i + 8'h80), 1'b0);
      if (i == 14) check("sat WCNT 15", {27'd0, WCNT}, 32'd15);
    end
    check("sat WCNT 16", {27'd0, WCNT}, 32'd16);
    rq.push_back('{4'd1, 16'h9111, 16'hFFFF});
    run_reads();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
